reg_file_wb: RTL and testbench

Register file that terminates the writeback interface of the pipeline. It accepts the write enable, destination address and writeback data that the WB stage presents each cycle, and stores them in the architectural registers. It also serves two synchronous read ports to the decode stage. Register x0 reads as zero, and an optional same-cycle write-to-read bypass can be compiled in.

---
 rtl/reg_file_wb.sv | 79 +++++++
 tb/tb_reg_file_wb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// Writeback-terminated register file: x0 hardwired to zero, two registered read ports.
// Optional same-edge write-to-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_file_write,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_rs1,
  input  logic [ADDR_WIDTH-1:0] addr_rs2,
  output logic [DATA_WIDTH-1:0] rs1_out,
  output logic [DATA_WIDTH-1:0] rs2_out,
  output logic                  rd_valid,
  output logic [7:0]            wr_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs    [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] rs1_next;
  logic [DATA_WIDTH-1:0] rs2_next;

  assign wr_fire = reg_file_write && (addr_wr != '0);

  // x0 has no storage; the read view supplies a constant zero in its slot.
  assign rd_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (wr_fire && (addr_wr == ADDR_WIDTH'(gi))) begin
          regs[gi] <= data_wr;
        end
      end
      assign rd_view[gi] = regs[gi];
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  // wr_fire already excludes x0, so a zero read address never picks up data_wr.
  assign rs1_next = (wr_fire && (addr_wr == addr_rs1)) ? data_wr : rd_view[addr_rs1];
  assign rs2_next = (wr_fire && (addr_wr == addr_rs2)) ? data_wr : rd_view[addr_rs2];
`else
  assign rs1_next = rd_view[addr_rs1];
  assign rs2_next = rd_view[addr_rs2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_out  <= '0;
      rs2_out  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rs1_out <= rs1_next;
        rs2_out <= rs2_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_fire && (wr_count != 8'hFF)) begin
      wr_count <= wr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: vector table plus reset, saturation and async-reset sequences.
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        reg_file_write;
  logic [4:0]  addr_wr;
  logic [31:0] data_wr;
  logic        rd_en;
  logic [4:0]  addr_rs1;
  logic [4:0]  addr_rs2;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic        rd_valid;
  logic [7:0]  wr_count;

  int checks = 0;
  int passes = 0;

  reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_file_write(reg_file_write), .addr_wr(addr_wr), .data_wr(data_wr),
    .rd_en(rd_en), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_valid(rd_valid), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic        re;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("check %-16s got %h ok", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                       input logic re, input logic [4:0] a1, input logic [4:0] a2);
    reg_file_write = wr;
    addr_wr        = aw;
    data_wr        = dw;
    rd_en          = re;
    addr_rs1       = a1;
    addr_rs2       = a2;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(31 - a));
      @(negedge clk);
      check($sformatf("%s.rs1[%0d]", tag, a), rs1_out, 32'd0);
      check($sformatf("%s.rs2[%0d]", tag, 31 - a), rs2_out, 32'd0);
      check($sformatf("%s.vld[%0d]", tag, a), {31'd0, rd_valid}, 32'd1);
    end
  endtask

  initial begin
    //               wr    aw     dw             re    a1     a2     e1              e2                         ev    ec
    vecs[0]  = '{1'b1, 5'd21, 32'hAAAAAAAA, 1'b0, 5'd0,  5'd0,  32'h0,          32'h0,                     1'b0, 8'd1};
    vecs[1]  = '{1'b1, 5'd27, 32'h55555555, 1'b0, 5'd0,  5'd0,  32'h0,          32'h0,                     1'b0, 8'd2};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd21, 5'd27, 32'hAAAAAAAA,   32'h55555555,              1'b1, 8'd2};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  32'hAAAAAAAA,   32'h55555555,              1'b0, 8'd2};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,          32'h0,                     1'b1, 8'd2};
    vecs[5]  = '{1'b0, 5'd28, 32'h12345678, 1'b0, 5'd0,  5'd0,  32'h0,          32'h0,                     1'b0, 8'd2};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd28, 5'd21, 32'h0,          32'hAAAAAAAA,              1'b1, 8'd2};
    vecs[7]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd27, 5'd27, 32'h55555555,   32'h55555555,              1'b1, 8'd3};
    vecs[8]  = '{1'b1, 5'd1,  32'h22222222, 1'b1, 5'd1,  5'd21, BYP ? 32'h22222222 : 32'h11111111,
                                                                                32'hAAAAAAAA,              1'b1, 8'd4};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  5'd1,  32'h22222222,   32'h22222222,              1'b1, 8'd4};
    vecs[10] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h22222222,   32'h22222222,              1'b0, 8'd5};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd0,  32'hDEADBEEF,   32'h0,                     1'b1, 8'd5};
    vecs[12] = '{1'b1, 5'd2,  32'hCAFEF00D, 1'b1, 5'd0,  5'd2,  32'h0,          BYP ? 32'hCAFEF00D : 32'h0, 1'b1, 8'd6};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  5'd31, 32'hCAFEF00D,   32'hDEADBEEF,              1'b1, 8'd6};

    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst.rs1", rs1_out, 32'd0);
    check("rst.rs2", rs2_out, 32'd0);
    check("rst.vld", {31'd0, rd_valid}, 32'd0);
    check("rst.cnt", {24'd0, wr_count}, 32'd0);

    // Traffic presented while reset is held must be ignored.
    drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 5'd3);
    @(negedge clk);
    @(negedge clk);
    check("inrst.vld", {31'd0, rd_valid}, 32'd0);
    check("inrst.cnt", {24'd0, wr_count}, 32'd0);
    check("inrst.rs1", rs1_out, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    rst_n = 1'b1;

    read_all_zero("post_rst");

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wr, vecs[i].aw, vecs[i].dw, vecs[i].re, vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      check($sformatf("vec%0d.rs1", i), rs1_out, vecs[i].e1);
      check($sformatf("vec%0d.rs2", i), rs2_out, vecs[i].e2);
      check($sformatf("vec%0d.vld", i), {31'd0, rd_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d.cnt", i), {24'd0, wr_count}, {24'd0, vecs[i].ec});
    end

    // 6 writes so far; 260 more must pin the counter at 255.
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 5'd5, 32'(i), 1'b0, 5'd0, 5'd0);
      @(negedge clk);
    end
    check("sat.cnt", {24'd0, wr_count}, 32'd255);
    drive(1'b1, 5'd6, 32'h66666666, 1'b1, 5'd5, 5'd21);
    @(negedge clk);
    check("sat.rs1", rs1_out, 32'd259);
    check("sat.rs2", rs2_out, 32'hAAAAAAAA);
    check("sat.hold", {24'd0, wr_count}, 32'd255);
    check("sat.vld", {31'd0, rd_valid}, 32'd1);

    // Reset dropped between edges with reads and writes still streaming.
    #2 rst_n = 1'b0;
    #1;
    check("async.rs1", rs1_out, 32'd0);
    check("async.rs2", rs2_out, 32'd0);
    check("async.vld", {31'd0, rd_valid}, 32'd0);
    check("async.cnt", {24'd0, wr_count}, 32'd0);
    @(negedge clk);
    check("async.vld2", {31'd0, rd_valid}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    rst_n = 1'b1;
    read_all_zero("post_async");
    check("post_async.cnt", {24'd0, wr_count}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
